// File: rtl/pkg_tpu.sv
// pkg_tpu: shared types, op encodings and latency helpers for the MA issue scheduler.
package pkg_tpu;
  typedef logic [3:0] issue_no_t;
  localparam logic [1:0] OP_CLASS_ADD = 2'b00;
  localparam logic [1:0] OP_CLASS_MLT = 2'b01;
  localparam logic [1:0] OPC_MAC = 2'b10;
  localparam logic [1:0] OPC_MAD = 2'b11;
  function automatic logic ma_fused(logic [1:0] cls, logic [1:0] code);
    return cls == OP_CLASS_MLT && (code == OPC_MAC || code == OPC_MAD);
  endfunction
  function automatic int ma_lat(logic [1:0] cls, logic [1:0] code, int dm, int da);
    return cls == OP_CLASS_ADD ? da : ma_fused(cls, code) ? dm + da : dm;
  endfunction
endpackage

// File: rtl/ma_issue_sched_if.sv
// ma_issue_sched_if: dispatch <-> scheduler bus; perf counters appear with MA_SCHED_PERF_EN.
interface ma_issue_sched_if import pkg_tpu::*; #(parameter int NUM_REQ = 2);
  logic I_Stall;
  logic [NUM_REQ-1:0] I_Req;
  logic [2*NUM_REQ-1:0] I_OpClass, I_OpCode;
  logic [NUM_REQ-1:0] O_Grant;
  logic O_Issue_En, O_WB_Expect, O_Busy;
  logic [1:0] O_OpClass, O_OpCode, O_Src;
  issue_no_t O_Issue_No;
`ifdef MA_SCHED_PERF_EN
  logic [31:0] O_Perf_Issue, O_Perf_Conflict;
  modport master(output I_Stall, I_Req, I_OpClass, I_OpCode,
                 input O_Grant, O_Issue_En, O_OpClass, O_OpCode, O_Src, O_Issue_No, O_WB_Expect, O_Busy,
                 O_Perf_Issue, O_Perf_Conflict);
  modport slave(input I_Stall, I_Req, I_OpClass, I_OpCode,
                output O_Grant, O_Issue_En, O_OpClass, O_OpCode, O_Src, O_Issue_No, O_WB_Expect, O_Busy,
                O_Perf_Issue, O_Perf_Conflict);
`else
  modport master(output I_Stall, I_Req, I_OpClass, I_OpCode,
                 input O_Grant, O_Issue_En, O_OpClass, O_OpCode, O_Src, O_Issue_No, O_WB_Expect, O_Busy);
  modport slave(input I_Stall, I_Req, I_OpClass, I_OpCode,
                output O_Grant, O_Issue_En, O_OpClass, O_OpCode, O_Src, O_Issue_No, O_WB_Expect, O_Busy);
`endif
endinterface

// File: rtl/ma_resv_shift.sv
// ma_resv_shift: writeback reservation and fused-op shift vectors (bit i = due in i cycles).
module ma_resv_shift #(
  parameter int W = 5,
  localparam int IW = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en_i,
  input  logic          set_i,
  input  logic          fused_i,
  input  logic [IW-1:0] idx_i,
  output logic [W-1:0]  resv_o,
  output logic          resv0_o,
  output logic          fdue_o
);
  logic [W-1:0] resv_q, resv_d, fused_q, fused_d, hot;
  always_comb begin
    hot = set_i ? W'(1) << idx_i : '0;
    resv_d = (resv_q >> 1) | hot;
    fused_d = (fused_q >> 1) | (fused_i ? hot : '0);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      resv_q <= '0;
      fused_q <= '0;
    end else if (en_i) begin
      resv_q <= resv_d;
      fused_q <= fused_d;
    end
  assign resv_o = resv_q;
  assign resv0_o = resv_q[0];
  // a fused op stops counting against the chain buffer as it shifts into bit 0
  assign fdue_o = fused_d[0];
endmodule

// File: rtl/ma_issue_sched.sv
// ma_issue_sched: round-robin MA issue with writeback-collision and fused-depth blocking.
// MA_SCHED_PERF_EN adds saturating issue/conflict counters.
module ma_issue_sched import pkg_tpu::*; #(
  parameter int DEPTH_MLT = 3,
  parameter int DEPTH_ADD = 1,
  parameter int NUM_REQ = 2
) (
  input logic clock,
  input logic reset,
  ma_issue_sched_if.slave bus
);
  localparam int LAT_MAX = DEPTH_MLT + DEPTH_ADD;
  localparam int LW = $clog2(LAT_MAX + 1);
  localparam int FW = $clog2(DEPTH_MLT + 1);
  logic [LAT_MAX:0] resv;
  logic resv0, fdue, issue, found;
  logic [NUM_REQ-1:0] elig;
  logic [1:0] ptr_q, ptr_d, win, cls, code;
  issue_no_t ino_q, ino_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_el
    assign elig[r] = bus.I_Req[r]
      & ~resv[LW'(ma_lat(bus.I_OpClass[2*r +: 2], bus.I_OpCode[2*r +: 2], DEPTH_MLT, DEPTH_ADD))]
      & ~(ma_fused(bus.I_OpClass[2*r +: 2], bus.I_OpCode[2*r +: 2]) & (fcnt_q == FW'(DEPTH_MLT)));
    assign bus.O_Grant[r] = issue && win == 2'(r);
  end
  always_comb begin
    found = 1'b0;
    win = '0;
    cls = '0;
    code = '0;
    // lowest eligible overall, then overridden by lowest eligible at or after the pointer
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (elig[j]) begin
        found = 1'b1;
        win = 2'(j);
      end
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (elig[j] && 2'(j) >= ptr_q) win = 2'(j);
    for (int j = 0; j < NUM_REQ; j++)
      if (win == 2'(j)) begin
        cls = bus.I_OpClass[2*j +: 2];
        code = bus.I_OpCode[2*j +: 2];
      end
    issue = found & ~bus.I_Stall & ~reset;
    ptr_d = issue ? (win == 2'(NUM_REQ - 1) ? 2'd0 : win + 2'd1) : ptr_q;
    ino_d = issue ? ino_q + 1'b1 : ino_q;
    fcnt_d = fcnt_q + FW'(issue & ma_fused(cls, code)) - FW'(fdue & ~bus.I_Stall);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ptr_q <= '0;
      ino_q <= '0;
      fcnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      ino_q <= ino_d;
      fcnt_q <= fcnt_d;
    end
  ma_resv_shift #(.W(LAT_MAX + 1)) u_resv (
    .clock   (clock),
    .reset   (reset),
    .en_i    (~bus.I_Stall),
    .set_i   (issue),
    .fused_i (ma_fused(cls, code)),
    .idx_i   (LW'(ma_lat(cls, code, DEPTH_MLT, DEPTH_ADD) - 1)),
    .resv_o  (resv),
    .resv0_o (resv0),
    .fdue_o  (fdue)
  );
  assign bus.O_Issue_En = issue;
  assign bus.O_OpClass = issue ? cls : '0;
  assign bus.O_OpCode = issue ? code : '0;
  assign bus.O_Src = issue ? win : '0;
  assign bus.O_Issue_No = ino_q;
  assign bus.O_WB_Expect = resv0 & ~bus.I_Stall;
  assign bus.O_Busy = |resv;
`ifdef MA_SCHED_PERF_EN
  logic [31:0] pi_q, pc_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pi_q <= '0;
      pc_q <= '0;
    end else begin
      if (issue && ~&pi_q) pi_q <= pi_q + 1'b1;
      if (|bus.I_Req && !bus.I_Stall && !issue && ~&pc_q) pc_q <= pc_q + 1'b1;
    end
  assign bus.O_Perf_Issue = pi_q;
  assign bus.O_Perf_Conflict = pc_q;
`endif
endmodule

// File: tb/tb_ma_issue_sched.sv
// tb_ma_issue_sched: directed scenarios plus random traffic against an in-flight-op list model.
module tb_ma_issue_sched;
  localparam int NR = 2, DM = 3, DA = 1;
  logic clk = 1'b0, rst = 1'b1;
  ma_issue_sched_if #(.NUM_REQ(NR)) bus ();
  ma_issue_sched #(.DEPTH_MLT(DM), .DEPTH_ADD(DA), .NUM_REQ(NR)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  // each in-flight op: cycles until its result leaves, and whether it is fused
  typedef struct { int r; bit f; } op_t;
  op_t inflight[$], nxt[$];
  int m_ptr = 0, m_ino = 0, win, fc, idx, c, o, wl, e_pi = 0, e_pc = 0;
  bit e_wb, wf;
  function automatic int lat_of(int cl, int op);
    return cl == 1 ? (op >= 2 ? DM + DA : DM) : DA;
  endfunction
  function automatic bit fus_of(int cl, int op);
    return cl == 1 && op >= 2;
  endfunction
  function automatic bit due(int l);
    foreach (inflight[i]) if (inflight[i].r == l) return 1'b1;
    return 1'b0;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      inflight.delete();
      m_ptr = 0;
      m_ino = 0;
      e_pi = 0;
      e_pc = 0;
      chk("rst_grant", int'(bus.O_Grant), 0);
      chk("rst_issue", int'(bus.O_Issue_En), 0);
      chk("rst_busy", int'(bus.O_Busy), 0);
      chk("rst_wb", int'(bus.O_WB_Expect), 0);
      chk("rst_no", int'(bus.O_Issue_No), 0);
    end else begin
      e_wb = 1'b0;
      fc = 0;
      foreach (inflight[i]) begin
        if (inflight[i].r == 0) e_wb = 1'b1;
        if (inflight[i].f && inflight[i].r > 0) fc++;
      end
      win = -1;
      wl = 0;
      wf = 1'b0;
      c = 0;
      o = 0;
      if (!bus.I_Stall)
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (win < 0 && bus.I_Req[idx] && !due(lat_of((int'(bus.I_OpClass) >> (2*idx)) & 3, (int'(bus.I_OpCode) >> (2*idx)) & 3))
              && !(fus_of((int'(bus.I_OpClass) >> (2*idx)) & 3, (int'(bus.I_OpCode) >> (2*idx)) & 3) && fc == DM)) begin
            win = idx;
            c = (int'(bus.I_OpClass) >> (2*idx)) & 3;
            o = (int'(bus.I_OpCode) >> (2*idx)) & 3;
            wl = lat_of(c, o);
            wf = fus_of(c, o);
          end
        end
      chk("grant", int'(bus.O_Grant), win < 0 ? 0 : 1 << win);
      chk("issue_en", int'(bus.O_Issue_En), win >= 0);
      chk("opclass", int'(bus.O_OpClass), c);
      chk("opcode", int'(bus.O_OpCode), o);
      chk("src", int'(bus.O_Src), win < 0 ? 0 : win);
      chk("issue_no", int'(bus.O_Issue_No), m_ino);
      chk("wb_expect", int'(bus.O_WB_Expect), e_wb && !bus.I_Stall);
      chk("busy", int'(bus.O_Busy), inflight.size() > 0);
      if (win >= 0) e_pi++;
      if (|bus.I_Req && !bus.I_Stall && win < 0) e_pc++;
`ifdef MA_SCHED_PERF_EN
      // counters reflect events before this cycle; compare before folding this cycle in
      chk("perf_issue", int'(bus.O_Perf_Issue), e_pi - (win >= 0));
      chk("perf_conflict", int'(bus.O_Perf_Conflict), e_pc - (|bus.I_Req && !bus.I_Stall && win < 0));
`endif
      if (!bus.I_Stall) begin
        nxt.delete();
        foreach (inflight[i]) if (inflight[i].r > 0) nxt.push_back('{r: inflight[i].r - 1, f: inflight[i].f});
        if (win >= 0) begin
          nxt.push_back('{r: wl - 1, f: wf});
          m_ptr = (win + 1) % NR;
          m_ino = (m_ino + 1) % 16;
        end
        inflight = nxt;
      end
    end
  end
  task automatic drive(bit st, logic [1:0] rq, logic [3:0] cl, logic [3:0] op);
    @(posedge clk);
    #1;
    bus.I_Stall = st;
    bus.I_Req = rq;
    bus.I_OpClass = cl;
    bus.I_OpCode = op;
    #2;
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.I_Req = '0;
    bus.I_Stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  int exp4[5] = '{1, 1, 1, 0, 1};
  int exp5[4] = '{0, 0, 0, 1};
  initial begin
    bus.I_Stall = 1'b0;
    bus.I_Req = '0;
    bus.I_OpClass = '0;
    bus.I_OpCode = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 2'b01, 4'b0000, 4'b0000);
    chk("t1_grant", int'(bus.O_Grant), 1);
    chk("t1_no", int'(bus.O_Issue_No), 0);
    drive(0, 2'b00, 4'b0000, 4'b0000);
    chk("t1_wb", int'(bus.O_WB_Expect), 1);
    drive(0, 2'b01, 4'b0001, 4'b0011);
    chk("t2_mad_grant", int'(bus.O_Grant), 1);
    drive(0, 2'b00, 4'b0000, 4'b0000);
    drive(0, 2'b00, 4'b0000, 4'b0000);
    drive(0, 2'b10, 4'b0000, 4'b0000);
    chk("t2_blocked", int'(bus.O_Grant), 0);
    drive(0, 2'b10, 4'b0000, 4'b0000);
    chk("t2_grant", int'(bus.O_Grant), 2);
    chk("t2_wb_mad", int'(bus.O_WB_Expect), 1);
    drive(0, 2'b00, 4'b0000, 4'b0000);
    chk("t2_wb_add", int'(bus.O_WB_Expect), 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b11, 4'b0000, 4'b0000);
      chk("t3_grant", int'(bus.O_Grant), (i % 2) ? 2 : 1);
      chk("t3_no", int'(bus.O_Issue_No), i);
    end
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 2'b01, 4'b0001, 4'b0010);
      chk("t4_mac_grant", int'(bus.O_Grant), exp4[i]);
    end
    drive(0, 2'b00, 4'b0000, 4'b0000);
    pulse_reset();
    drive(0, 2'b01, 4'b0001, 4'b0011);
    drive(1, 2'b01, 4'b0000, 4'b0000);
    chk("t5_stall_grant", int'(bus.O_Grant), 0);
    chk("t5_stall_busy", int'(bus.O_Busy), 1);
    drive(1, 2'b00, 4'b0000, 4'b0000);
    chk("t5_stall_wb", int'(bus.O_WB_Expect), 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b00, 4'b0000, 4'b0000);
      chk("t5_wb", int'(bus.O_WB_Expect), exp5[i]);
    end
    pulse_reset();
    repeat (3) drive(0, 2'b01, 4'b0001, 4'b0010);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("t6_grant", int'(bus.O_Grant), 0);
    chk("t6_issue", int'(bus.O_Issue_En), 0);
    chk("t6_busy", int'(bus.O_Busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.I_Req = '0;
    drive(0, 2'b01, 4'b0000, 4'b0000);
    chk("t6_issue_no", int'(bus.O_Issue_No), 0);
    chk("t6_grant_after", int'(bus.O_Grant), 1);
    repeat (3000) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      bus.I_Stall = ($urandom_range(0, 99) < 15);
      bus.I_Req = 2'($urandom);
      bus.I_OpClass = {1'b0, 1'($urandom), 1'b0, 1'($urandom)};
      bus.I_OpCode = 4'($urandom);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.I_Req = '0;
    bus.I_Stall = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
